// File: rtl/aes_key_schedule_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : aes_key_schedule_seq (with helper package aes_pkg)
//  Brief    : Sequential AES key expansion, one word per cycle, with a
//             registered round-key read port for an iterative cipher core.
//             Optional macro AES_KEY_SCHEDULE_INV_EN adds rd_inv, which
//             returns InvMixColumns-transformed keys for the
//             equivalent inverse cipher.
//  Revision : 1.0  initial release
// ============================================================================

package aes_pkg;

    // AES S-box, entry 0 in the most significant byte
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column; the leading byte is row 0
    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] a  [0:3];
        logic [7:0] m9 [0:3];
        logic [7:0] mb [0:3];
        logic [7:0] md [0:3];
        logic [7:0] me [0:3];
        logic [7:0] x2, x4, x8;
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            a[k]  = w[31-8*k -: 8];
            x2    = xtime(a[k]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[k] = x8 ^ a[k];
            mb[k] = x8 ^ x2 ^ a[k];
            md[k] = x8 ^ x4 ^ a[k];
            me[k] = x8 ^ x4 ^ x2;
        end
        for (int k = 0; k < 4; k++) begin
            res[31-8*k -: 8] = me[k] ^ mb[(k+1)%4] ^ md[(k+2)%4] ^ m9[(k+3)%4];
        end
        return res;
    endfunction

endpackage

module aes_key_schedule_seq #(
    parameter int NK = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [32*NK-1:0]          key,
    output logic                      busy,
    output logic                      done,
    input  logic                      rd_en,
    input  logic [$clog2(NK+7)-1:0]   rd_round,
`ifdef AES_KEY_SCHEDULE_INV_EN
    input  logic                      rd_inv,
`endif
    output logic                      rd_valid,
    output logic [127:0]              rd_rkey
);

    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int IW = $clog2(NW);
    localparam int RW = $clog2(NR + 1);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_key_schedule_seq: NK must be 4, 6 or 8");
    end

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_EXPAND = 1'b1} state_t;

    state_t         r_state;
    logic [IW-1:0]  r_i;
    logic [3:0]     r_phase;      // i mod NK, tracked incrementally
    logic [7:0]     r_rcon;
    logic [31:0]    r_win [0:NK-1];   // sliding window w[i-NK] .. w[i-1]
    logic [31:0]    r_w   [0:NW-1];

    logic [31:0]    w_sub_in;
    logic [31:0]    w_sub_out;
    logic [31:0]    w_new;
    logic           w_round_ok;
    logic [127:0]   w_fwd_key;
    logic [127:0]   w_rd_key;

    // Next expanded word through the single shared SubWord datapath; rcon
    // occupies the leading byte of the word
    always_comb begin
        w_sub_in  = (r_phase == 4'd0) ? aes_pkg::rot_word(r_win[NK-1]) : r_win[NK-1];
        w_sub_out = aes_pkg::sub_word(w_sub_in);
        if (r_phase == 4'd0)
            w_new = r_win[0] ^ w_sub_out ^ {r_rcon, 24'h0};
        else if (NK == 8 && r_phase == 4'd4)
            w_new = r_win[0] ^ w_sub_out;
        else
            w_new = r_win[0] ^ r_win[NK-1];
    end

    // Expansion control: load restarts from any state, done is a level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_phase <= '0;
            r_rcon  <= 8'h01;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (load) begin
            r_state <= S_EXPAND;
            r_i     <= IW'(NK);
            r_phase <= '0;
            r_rcon  <= 8'h01;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else if (r_state == S_EXPAND) begin
            if (r_phase == 4'd0)
                r_rcon <= aes_pkg::xtime(r_rcon);
            r_phase <= (r_phase == 4'(NK-1)) ? 4'd0 : r_phase + 4'd1;
            r_i     <= r_i + IW'(1);
            if (r_i == IW'(NW-1)) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

    // Word storage and window; contents are unreadable until done, so no reset
    always_ff @(posedge clk) begin
        if (load) begin
            for (int j = 0; j < NK; j++) begin
                r_win[j] <= key[32*j +: 32];
                r_w[j]   <= key[32*j +: 32];
            end
        end else if (r_state == S_EXPAND) begin
            r_w[r_i] <= w_new;
            for (int j = 0; j < NK-1; j++)
                r_win[j] <= r_win[j+1];
            r_win[NK-1] <= w_new;
        end
    end

    // Forward round-key select
    always_comb begin
        w_fwd_key = '0;
        for (int r = 0; r <= NR; r++) begin
            if (rd_round == RW'(r))
                w_fwd_key = {r_w[4*r+3], r_w[4*r+2], r_w[4*r+1], r_w[4*r]};
        end
    end

`ifdef AES_KEY_SCHEDULE_INV_EN
    // Decryption key for middle rounds; first and last rounds pass through
    always_comb begin
        w_rd_key = w_fwd_key;
        if (rd_inv && rd_round != '0 && rd_round < RW'(NR)) begin
            for (int k = 0; k < 4; k++)
                w_rd_key[32*k +: 32] = aes_pkg::inv_mix_word(w_fwd_key[32*k +: 32]);
        end
    end
`else
    assign w_rd_key = w_fwd_key;
`endif

    assign w_round_ok = (rd_round <= RW'(NR));

    // Registered read port; a rejected read leaves rd_rkey unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_rkey  <= '0;
        end else if (rd_en && done && w_round_ok && !load) begin
            rd_valid <= 1'b1;
            rd_rkey  <= w_rd_key;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_key_schedule_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_aes_key_schedule_seq
//  Brief    : Self-checking bench for aes_key_schedule_seq at NK = 4, 6, 8
//             against a GF(2^8) arithmetic model of the key expansion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_key_schedule_seq;

`ifdef AES_KEY_SCHEDULE_INV_EN
    localparam bit INV_BUILD = 1'b1;
`else
    localparam bit INV_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [255:0] key_bus;
    logic         rd_en;
    logic [3:0]   rd_round;
`ifdef AES_KEY_SCHEDULE_INV_EN
    logic         rd_inv;
`endif
    int           sel;
    int           checks = 0;
    int           errors = 0;

    logic load4, load6, load8;
    logic busy4, busy6, busy8, done4, done6, done8, rv4, rv6, rv8;
    logic [127:0] rk4, rk6, rk8;
    logic busy, done, rd_valid;
    logic [127:0] rd_rkey;

    assign load4 = load && (sel == 4);
    assign load6 = load && (sel == 6);
    assign load8 = load && (sel == 8);
    assign busy     = (sel == 4) ? busy4 : (sel == 6) ? busy6 : busy8;
    assign done     = (sel == 4) ? done4 : (sel == 6) ? done6 : done8;
    assign rd_valid = (sel == 4) ? rv4   : (sel == 6) ? rv6   : rv8;
    assign rd_rkey  = (sel == 4) ? rk4   : (sel == 6) ? rk6   : rk8;

    always #5 clk = ~clk;

    aes_key_schedule_seq #(.NK(4)) u_dut4 (
        .clk(clk), .reset(reset), .load(load4), .key(key_bus[127:0]),
        .busy(busy4), .done(done4), .rd_en(rd_en), .rd_round(rd_round),
`ifdef AES_KEY_SCHEDULE_INV_EN
        .rd_inv(rd_inv),
`endif
        .rd_valid(rv4), .rd_rkey(rk4));

    aes_key_schedule_seq #(.NK(6)) u_dut6 (
        .clk(clk), .reset(reset), .load(load6), .key(key_bus[191:0]),
        .busy(busy6), .done(done6), .rd_en(rd_en), .rd_round(rd_round),
`ifdef AES_KEY_SCHEDULE_INV_EN
        .rd_inv(rd_inv),
`endif
        .rd_valid(rv6), .rd_rkey(rk6));

    aes_key_schedule_seq #(.NK(8)) u_dut8 (
        .clk(clk), .reset(reset), .load(load8), .key(key_bus),
        .busy(busy8), .done(done8), .rd_en(rd_en), .rd_round(rd_round),
`ifdef AES_KEY_SCHEDULE_INV_EN
        .rd_inv(rd_inv),
`endif
        .rd_valid(rv8), .rd_rkey(rk8));

    // ---------------- reference model ----------------
    logic [7:0]  m_sbox [0:255];
    logic [31:0] m_w    [0:59];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box from multiplicative inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv;
            for (int r = 1; r <= 4; r++)
                s = s ^ ((inv << r) | (inv >> (8 - r)));
            m_sbox[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] m_sub(input logic [31:0] w);
        return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
    endfunction

    function automatic logic [31:0] m_invmix(input logic [31:0] w);
        logic [7:0]  c [0:3];
        logic [7:0]  o;
        logic [31:0] res;
        c[0] = 8'h0e; c[1] = 8'h0b; c[2] = 8'h0d; c[3] = 8'h09;
        for (int i = 0; i < 4; i++) begin
            o = 8'h00;
            for (int j = 0; j < 4; j++)
                o = o ^ gf_mul(c[(j - i + 4) % 4], w[31-8*j -: 8]);
            res[31-8*i -: 8] = o;
        end
        return res;
    endfunction

    task automatic model_expand(input logic [255:0] k, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) m_w[i] = k[32*i +: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = m_w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int e = 1; e < i / nk; e++) rc = gf_mul(rc, 8'h02);
                t = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = m_sub(t);
            end
            m_w[i] = m_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rkey(input int r, input bit inv, input int nr);
        logic [127:0] v;
        logic [31:0]  w;
        for (int k = 0; k < 4; k++) begin
            w = m_w[4*r+k];
            if (INV_BUILD && inv && r > 0 && r < nr) w = m_invmix(w);
            v[32*k +: 32] = w;
        end
        return v;
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic do_load(input logic [255:0] k);
        key_bus = k;
        load    = 1'b1;
        @(posedge clk); #1;
        load    = 1'b0;
        key_bus = ~k;
    endtask

    task automatic do_read(input int r, input bit inv);
        rd_en    = 1'b1;
        rd_round = 4'(r);
`ifdef AES_KEY_SCHEDULE_INV_EN
        rd_inv   = inv;
`endif
        @(posedge clk); #1;
        rd_en    = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input string name);
        int n = 0;
        bit seen = 1'b0;
        while (n < 200 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) seen = 1'b1;
            else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_during_expand cycle %0d got %b exp 1", name, n, busy);
                end
            end
        end
        checks++;
        if (!seen || n != exp_cyc) begin
            errors++;
            $display("FAIL %s latency got %0d (seen=%0b) exp %0d", name, n, seen, exp_cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_with_done got %b exp 0", name, busy);
        end
    endtask

    // Back-to-back reads of every round, one per cycle
    task automatic read_all(input int nk, input bit inv, input string name);
        int nr = nk + 6;
        rd_en    = 1'b1;
        rd_round = 4'd0;
`ifdef AES_KEY_SCHEDULE_INV_EN
        rd_inv   = inv;
`endif
        @(posedge clk); #1;
        for (int r = 0; r <= nr; r++) begin
            if (r < nr) rd_round = 4'(r + 1);
            else        rd_en = 1'b0;
            checks++;
            if (rd_valid !== 1'b1 || rd_rkey !== exp_rkey(r, inv, nr)) begin
                errors++;
                $display("FAIL %s round %0d got v=%b %h exp v=1 %h",
                         name, r, rd_valid, rd_rkey, exp_rkey(r, inv, nr));
            end
            if (r < nr) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int s = 4; s <= 8; s += 2) begin
            sel = s;
            #0;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_rkey !== 128'h0) begin
                errors++;
                $display("FAIL reset_state nk=%0d got b=%b d=%b v=%b k=%h exp 0 0 0 0",
                         s, busy, done, rd_valid, rd_rkey);
            end
        end
        sel = 4;
        do_read(0, 1'b0);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_before_load got %b exp 0", rd_valid);
        end
    endtask

    task automatic test_fips128();
        logic [255:0] k = {128'h0, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
        sel = 4;
        model_expand(k, 4);
        do_load(k);
        wait_done(40, "fips128");
        do_read(1, 1'b0);
        checks++;
        if (rd_valid !== 1'b1 || rd_rkey !== {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17}) begin
            errors++;
            $display("FAIL fips128_round1 got v=%b %h exp v=1 2a6c760523a3393988542cb1a0fafe17", rd_valid, rd_rkey);
        end
        do_read(10, 1'b0);
        checks++;
        if (rd_valid !== 1'b1 || rd_rkey !== {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8}) begin
            errors++;
            $display("FAIL fips128_round10 got v=%b %h exp v=1 b6630ca6e13f0cc8c9ee2589d014f9a8", rd_valid, rd_rkey);
        end
        do_read(11, 1'b0);
        checks++;
        if (rd_valid !== 1'b0 || rd_rkey !== {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8}) begin
            errors++;
            $display("FAIL round_out_of_range got v=%b %h exp v=0 held round10", rd_valid, rd_rkey);
        end
        read_all(4, 1'b0, "fips128_all");
    endtask

    task automatic test_fips192();
        logic [255:0] k = {64'h0, 32'h522c6b7b, 32'h62f8ead2, 32'h809079e5,
                           32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
        sel = 6;
        model_expand(k, 6);
        do_load(k);
        wait_done(46, "fips192");
        do_read(12, 1'b0);
        checks++;
        if (rd_valid !== 1'b1 || rd_rkey[127:96] !== 32'h01002202) begin
            errors++;
            $display("FAIL fips192_w51 got v=%b %h exp v=1 01002202", rd_valid, rd_rkey[127:96]);
        end
        do_read(0, 1'b0);
        checks++;
        if (rd_valid !== 1'b1 || rd_rkey !== k[127:0]) begin
            errors++;
            $display("FAIL fips192_round0 got %h exp %h", rd_rkey, k[127:0]);
        end
        read_all(6, 1'b0, "fips192_all");
    endtask

    task automatic test_fips256();
        logic [255:0] k = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                           32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};
        sel = 8;
        model_expand(k, 8);
        do_load(k);
        wait_done(52, "fips256");
        do_read(14, 1'b0);
        checks++;
        if (rd_valid !== 1'b1 || rd_rkey[127:96] !== 32'h706c631e) begin
            errors++;
            $display("FAIL fips256_w59 got v=%b %h exp v=1 706c631e", rd_valid, rd_rkey[127:96]);
        end
        read_all(8, 1'b0, "fips256_all");
    endtask

    task automatic test_random_keys();
        logic [255:0] k;
        for (int s = 4; s <= 8; s += 2) begin
            for (int it = 0; it < 2; it++) begin
                sel = s;
                for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
                model_expand(k, s);
                do_load(k);
                wait_done(4 * (s + 7) - s, "random_latency");
                read_all(s, 1'b0, "random_keys");
            end
        end
    endtask

    task automatic test_restart_and_guards();
        logic [255:0] ka, kb;
        sel = 4;
        for (int j = 0; j < 8; j++) begin
            ka[32*j +: 32] = $urandom;
            kb[32*j +: 32] = $urandom;
        end
        do_load(ka);
        do_read(2, 1'b0);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_before_done got %b exp 0", rd_valid);
        end
        repeat (18) begin
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_mid_expand got %b exp 0", done);
        end
        do_load(kb);
        wait_done(40, "restart");
        model_expand(kb, 4);
        read_all(4, 1'b0, "restart_keys");
        // load and read in the same cycle: load wins, rd_rkey holds round 10
        key_bus  = kb;
        load     = 1'b1;
        rd_en    = 1'b1;
        rd_round = 4'd3;
        @(posedge clk); #1;
        load  = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_rkey !== exp_rkey(10, 1'b0, 10)) begin
            errors++;
            $display("FAIL load_and_read got v=%b %h exp v=0 %h", rd_valid, rd_rkey, exp_rkey(10, 1'b0, 10));
        end
        wait_done(40, "reload_same");
    endtask

    task automatic test_async_reset();
        logic [255:0] k;
        sel = 4;
        for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
        do_load(k);
        repeat (10) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_expand got b=%b d=%b v=%b exp 0 0 0", busy, done, rd_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
        end
        do_read(0, 1'b0);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_resume_after_reset got b=%b d=%b v=%b exp 0 0 0", busy, done, rd_valid);
        end
        model_expand(k, 4);
        do_load(k);
        wait_done(40, "post_reset");
        do_read(5, 1'b0);
        checks++;
        if (rd_valid !== 1'b1 || rd_rkey !== exp_rkey(5, 1'b0, 10)) begin
            errors++;
            $display("FAIL post_reset_read got v=%b %h exp v=1 %h", rd_valid, rd_rkey, exp_rkey(5, 1'b0, 10));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || rd_valid !== 1'b0 || rd_rkey !== 128'h0) begin
            errors++;
            $display("FAIL async_reset_done got d=%b v=%b k=%h exp 0 0 0", done, rd_valid, rd_rkey);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

`ifdef AES_KEY_SCHEDULE_INV_EN
    task automatic test_inv();
        logic [255:0] k = {128'h0, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
        logic [127:0] e1;
        sel = 4;
        model_expand(k, 4);
        do_load(k);
        wait_done(40, "inv_load");
        do_read(0, 1'b1);
        checks++;
        if (rd_valid !== 1'b1 || rd_rkey !== k[127:0]) begin
            errors++;
            $display("FAIL inv_round0 got v=%b %h exp v=1 %h", rd_valid, rd_rkey, k[127:0]);
        end
        do_read(10, 1'b1);
        checks++;
        if (rd_valid !== 1'b1 || rd_rkey !== {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8}) begin
            errors++;
            $display("FAIL inv_round10 got v=%b %h exp v=1 b6630ca6e13f0cc8c9ee2589d014f9a8", rd_valid, rd_rkey);
        end
        e1 = {m_invmix(32'h2a6c7605), m_invmix(32'h23a33939),
              m_invmix(32'h88542cb1), m_invmix(32'ha0fafe17)};
        do_read(1, 1'b1);
        checks++;
        if (rd_valid !== 1'b1 || rd_rkey !== e1) begin
            errors++;
            $display("FAIL inv_round1 got v=%b %h exp v=1 %h", rd_valid, rd_rkey, e1);
        end
        read_all(4, 1'b1, "inv_all");
        read_all(4, 1'b0, "fwd_after_inv");
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        sel      = 4;
        reset    = 1'b1;
        load     = 1'b0;
        key_bus  = '0;
        rd_en    = 1'b0;
        rd_round = 4'd0;
`ifdef AES_KEY_SCHEDULE_INV_EN
        rd_inv   = 1'b0;
`endif
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_fips128();
        test_fips192();
        test_fips256();
        test_random_keys();
        test_restart_and_guards();
        test_async_reset();
`ifdef AES_KEY_SCHEDULE_INV_EN
        test_inv();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
